// File: rtl/refill_arbiter.sv
// -----------------------------------------------------------------------------
// refill_arbiter
//
// Purpose
//   Shares one word-wide backing-memory read port between the L1 instruction
//   cache and the L1 data cache.  On a miss, one side is granted and its whole
//   line (BURST_WORDS words, line-aligned) is fetched one word at a time:
//   request, wait for the returned word, write it into the granted cache.
//   The CPU pipeline is stalled while any miss is pending or a refill is running.
//
// Parameters
//   BURST_WORDS  words per refill burst (power of two, 1..16)
//   ADDR_W       physical byte-address width
//
// Optional feature
//   REFILL_ROUND_ROBIN_EN  defined   : simultaneous misses alternate between the
//                                      sides (D-side wins the first tie after
//                                      reset).
//                          undefined : simultaneous misses always go to the
//                                      D-side; no last-grant state is kept.
//
// Ports
//   CLK_CPU            in   sole clock, rising edge
//   RST                in   synchronous active-high reset
//   icache_miss        in   level miss request from L1I
//   dcache_miss        in   level miss request from L1D
//   icache_miss_addr   in   byte address of the missing I-side word
//   dcache_miss_addr   in   byte address of the missing D-side word
//   icache_fetch       out  one-cycle write strobe into L1I
//   dcache_fetch       out  one-cycle write strobe into L1D
//   refill_addr        out  byte address written on a fetch strobe
//   refill_data        out  data word written on a fetch strobe
//   mem_req            out  one-cycle word read request to backing memory
//   mem_addr           out  byte address of the read request
//   mem_valid          in   read data valid (one cycle)
//   mem_rdata          in   read data
//   stall              out  pipeline hold (any miss or busy)
//   busy               out  refill engine is not idle
// -----------------------------------------------------------------------------
module refill_arbiter #(
  parameter int BURST_WORDS = 4,
  parameter int ADDR_W      = 20
) (
  input  logic              CLK_CPU,
  input  logic              RST,
  input  logic              icache_miss,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  output logic              icache_fetch,
  output logic              dcache_fetch,
  output logic [ADDR_W-1:0] refill_addr,
  output logic [31:0]       refill_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              busy
);

  // Counter needs at least one bit even for single-word bursts.
  localparam int CNT_W     = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  // Byte-offset bits inside one line: word index bits plus the 2 byte bits.
  localparam int LINE_BITS = $clog2(BURST_WORDS) + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_BITS) - ADDR_W'(1));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_WORDS - 1);

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       data_q,  data_d;
`ifdef REFILL_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic              grant_sel;
  logic [ADDR_W-1:0] miss_addr_vec [2];
  logic [1:0]        fetch_vec;
  logic [ADDR_W-1:0] word_addr;

  assign miss_addr_vec[SIDE_I] = icache_miss_addr;
  assign miss_addr_vec[SIDE_D] = dcache_miss_addr;

  // ---------------------------------------------------------------------------
  // Arbitration.  A lone requester always wins; only ties consult the policy.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_sel = SIDE_I;
`ifdef REFILL_ROUND_ROBIN_EN
    if (icache_miss && dcache_miss) begin
      grant_sel = ~last_grant_q;
    end else if (dcache_miss) begin
      grant_sel = SIDE_D;
    end
`else
    if (dcache_miss) begin
      grant_sel = SIDE_D;
    end
`endif
  end

  // Current word address.  The base is line aligned, so adding the word offset
  // never carries out of the line; the ADDR_W-wide sum wraps naturally.
  assign word_addr = base_q + (ADDR_W'(cnt_q) << 2);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
`ifdef REFILL_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (icache_miss || dcache_miss) begin
          grant_d = grant_sel;
          base_d  = miss_addr_vec[grant_sel] & LINE_MASK;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
      end

      // mem_valid is only looked at here; strays in other states are dropped.
      ST_WAIT: begin
        if (mem_valid) begin
          data_d  = mem_rdata;
          state_d = ST_WRITE;
        end
      end

      // The counter holds on the last word so it never leaves 0..BURST_WORDS-1.
      ST_WRITE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_REQ;
        end
      end

      ST_DONE: begin
`ifdef REFILL_ROUND_ROBIN_EN
        last_grant_d = grant_q;
`endif
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_CPU) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= SIDE_I;
      base_q       <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
`ifdef REFILL_ROUND_ROBIN_EN
      last_grant_q <= SIDE_I;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
`ifdef REFILL_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state only (except stall, which must also
  // react to a miss in the same cycle it is raised).
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_side
    localparam logic SIDE = (gi == 1);
    assign fetch_vec[gi] = (state_q == ST_WRITE) && (grant_q == SIDE);
  end

  assign icache_fetch = fetch_vec[SIDE_I];
  assign dcache_fetch = fetch_vec[SIDE_D];

  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = (state_q == ST_REQ)   ? word_addr : '0;
  assign refill_addr = (state_q == ST_WRITE) ? word_addr : '0;
  assign refill_data = (state_q == ST_WRITE) ? data_q    : '0;

  assign busy  = (state_q != ST_IDLE);
  assign stall = icache_miss | dcache_miss | busy;

endmodule

// File: tb/tb_refill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_refill_arbiter
//
// Self-checking bench for refill_arbiter (BURST_WORDS=4, ADDR_W=20).  The bench
// plays the backing memory, returns random words after random delays, and
// compares each burst against a line-level reference: the expected grant from
// the tie policy, the line-aligned word addresses, the returned data order and
// the burst length in cycles.
// -----------------------------------------------------------------------------
module tb_refill_arbiter;

  localparam int BW = 4;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_miss, dcache_miss;
  logic [AW-1:0] icache_miss_addr, dcache_miss_addr;
  logic          icache_fetch, dcache_fetch;
  logic [AW-1:0] refill_addr;
  logic [31:0]   refill_data;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [31:0]   mem_rdata;
  logic          stall, busy;

  always #5 clk = ~clk;

  refill_arbiter #(.BURST_WORDS(BW), .ADDR_W(AW)) dut (
    .CLK_CPU          (clk),
    .RST              (rst),
    .icache_miss      (icache_miss),
    .dcache_miss      (dcache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss_addr (dcache_miss_addr),
    .icache_fetch     (icache_fetch),
    .dcache_fetch     (dcache_fetch),
    .refill_addr      (refill_addr),
    .refill_data      (refill_data),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_valid        (mem_valid),
    .mem_rdata        (mem_rdata),
    .stall            (stall),
    .busy             (busy)
  );

  int checks   = 0;
  int failures = 0;
  logic tb_last;  // side of the last completed burst, 0 = I, 1 = D

  // Observations from one burst
  logic [AW-1:0] obs_maddr [$];
  logic [AW-1:0] obs_faddr [$];
  logic [31:0]   obs_fdata [$];
  logic          obs_fside [$];
  logic [31:0]   sent_data [$];
  int            busy_cycles, extra_wait, stall_bad, req_first;
  bit            timed_out;

  typedef struct {
    bit            im;
    bit            dm;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    int            d;       // 0 = random memory delay
    bit            noise;   // stray mem_valid during REQ
    bit            perturb; // change addresses / drop misses mid-burst
  } scen_t;

  function automatic logic expected_side(input bit im, input bit dm);
    if (im && !dm) return 1'b0;
    if (dm && !im) return 1'b1;
`ifdef REFILL_ROUND_ROBIN_EN
    return ~tb_last;
`else
    return 1'b1;
`endif
  endfunction

  // Plays backing memory for one burst and records everything seen, from the
  // first cycle after the grant up to the first idle cycle.
  task automatic run_burst(input int fixed_d, input bit noise, input bit perturb);
    int  countdown;
    int  d;
    bit  seen_busy;
    obs_maddr.delete(); obs_faddr.delete(); obs_fdata.delete();
    obs_fside.delete(); sent_data.delete();
    busy_cycles = 0; extra_wait = 0; stall_bad = 0; req_first = -1;
    timed_out = 1'b1; countdown = 0; seen_busy = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (stall !== (icache_miss | dcache_miss | busy)) stall_bad++;
      if (icache_fetch === 1'b1) begin
        obs_faddr.push_back(refill_addr); obs_fdata.push_back(refill_data);
        obs_fside.push_back(1'b0);
      end
      if (dcache_fetch === 1'b1) begin
        obs_faddr.push_back(refill_addr); obs_fdata.push_back(refill_data);
        obs_fside.push_back(1'b1);
      end
      if (busy === 1'b1) begin
        seen_busy = 1'b1;
        busy_cycles++;
      end else if (seen_busy) begin
        timed_out = 1'b0;
        break;
      end
      mem_valid = 1'b0;
      mem_rdata = $urandom;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          mem_valid = 1'b1;
          mem_rdata = $urandom;
          sent_data.push_back(mem_rdata);
        end
      end
      if (mem_req === 1'b1) begin
        if (req_first < 0) req_first = cyc;
        obs_maddr.push_back(mem_addr);
        d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, 4));
        extra_wait += d - 1;
        countdown = d;
        if (noise) begin
          mem_valid = 1'b1;
          mem_rdata = 32'hDEAD0000 ^ $urandom;
        end
      end
      if (perturb && cyc == 2) begin
        icache_miss_addr = AW'($urandom);
        dcache_miss_addr = AW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          icache_miss = 1'b0;
          dcache_miss = 1'b0;
        end
      end
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; icache_miss = 1'b1; dcache_miss = 1'b0;
    icache_miss_addr = 20'h00124; dcache_miss_addr = '0;
    mem_valid = 1'b0; mem_rdata = '0; tb_last = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if ({mem_req, icache_fetch, dcache_fetch} !== 3'b000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000", {mem_req, icache_fetch, dcache_fetch});
    end
    checks++;
    if ({mem_addr, refill_addr, refill_data} !== '0) begin
      failures++; $display("FAIL reset_buses got=%h/%h/%h exp=0", mem_addr, refill_addr, refill_data);
    end
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall_miss got=%b exp=1", stall); end
    icache_miss = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_spurious_valid();
    int strobes = 0;
    int busies  = 0;
    mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (icache_fetch || dcache_fetch || mem_req) strobes++;
      if (busy) busies++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL idle_valid_strobes got=%0d exp=0", strobes); end
    checks++;
    if (busies !== 0) begin failures++; $display("FAIL idle_valid_busy got=%0d exp=0", busies); end
    $display("test_spurious_valid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bursts();
    scen_t         sc [$];
    scen_t         s;
    logic          exp_side;
    logic [AW-1:0] base, ea;
    int            exp_busy;
    // Directed: single I miss, tie twice back-to-back, top-of-memory D line
    sc.push_back('{1, 0, 20'h00124, 20'h00000, 2, 0, 0});
    sc.push_back('{1, 1, 20'h00344, 20'h00588, 2, 0, 0});
    sc.push_back('{1, 1, 20'h00344, 20'h00588, 1, 0, 0});
    sc.push_back('{0, 1, 20'h00000, 20'hFFFFC, 1, 1, 0});
    for (int r = 0; r < 24; r++) begin
      s.im = ($urandom_range(0, 1) == 1);
      s.dm = s.im ? ($urandom_range(0, 1) == 1) : 1'b1;
      s.ia = AW'($urandom); s.da = AW'($urandom);
      s.d = 0;
      s.noise = ($urandom_range(0, 2) == 0);
      s.perturb = ($urandom_range(0, 2) == 0);
      sc.push_back(s);
    end
    for (int i = 0; i < sc.size(); i++) begin
      s = sc[i];
      icache_miss = s.im; dcache_miss = s.dm;
      icache_miss_addr = s.ia; dcache_miss_addr = s.da;
      exp_side = expected_side(s.im, s.dm);
      base = (exp_side ? s.da : s.ia) & ~AW'(BW * 4 - 1);
      run_burst(s.d, s.noise, s.perturb);
      exp_busy = 3 * BW + extra_wait + 1;
      checks++;
      if (timed_out) begin failures++; $display("FAIL burst%0d_timeout no return to idle", i); end
      checks++;
      if (req_first !== 0) begin failures++; $display("FAIL burst%0d_first_req got_cycle=%0d exp=0", i, req_first); end
      checks++;
      if (obs_maddr.size() !== BW) begin failures++; $display("FAIL burst%0d_req_count got=%0d exp=%0d", i, obs_maddr.size(), BW); end
      checks++;
      if (obs_fside.size() !== BW) begin failures++; $display("FAIL burst%0d_fetch_count got=%0d exp=%0d", i, obs_fside.size(), BW); end
      for (int k = 0; k < BW; k++) begin
        ea = base + AW'(4 * k);
        if (k < obs_maddr.size()) begin
          checks++;
          if (obs_maddr[k] !== ea) begin failures++; $display("FAIL burst%0d_mem_addr%0d got=%h exp=%h", i, k, obs_maddr[k], ea); end
        end
        if (k < obs_fside.size() && k < sent_data.size()) begin
          checks++;
          if (obs_fside[k] !== exp_side || obs_faddr[k] !== ea || obs_fdata[k] !== sent_data[k]) begin
            failures++;
            $display("FAIL burst%0d_fetch%0d got side=%b addr=%h data=%h exp side=%b addr=%h data=%h",
                     i, k, obs_fside[k], obs_faddr[k], obs_fdata[k], exp_side, ea, sent_data[k]);
          end
        end
      end
      checks++;
      if (busy_cycles !== exp_busy) begin failures++; $display("FAIL burst%0d_latency got=%0d exp=%0d", i, busy_cycles, exp_busy); end
      checks++;
      if (stall_bad !== 0) begin failures++; $display("FAIL burst%0d_stall bad_cycles=%0d exp=0", i, stall_bad); end
      if (i == 0 && obs_maddr.size() == BW) begin
        checks++;
        if (obs_maddr[0] !== 20'h00120 || obs_maddr[3] !== 20'h0012C) begin
          failures++; $display("FAIL single_i_addrs got=%h..%h exp=00120..0012c", obs_maddr[0], obs_maddr[3]);
        end
      end
      if (i == 3 && obs_maddr.size() == BW) begin
        checks++;
        if (obs_maddr[0] !== 20'hFFFF0 || obs_maddr[3] !== 20'hFFFFC) begin
          failures++; $display("FAIL top_line_addrs got=%h..%h exp=ffff0..ffffc", obs_maddr[0], obs_maddr[3]);
        end
      end
      $display("burst %0d im=%b dm=%b side=%b base=%h waits=%0d busy=%0d", i, s.im, s.dm, exp_side, base, extra_wait, busy_cycles);
      tb_last = exp_side;
    end
    icache_miss = 1'b0; dcache_miss = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL bursts_final_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    int nreq = 0;
    int nfetch = 0;
    bit pend = 1'b0;
    bit reached = 1'b0;
    icache_miss = 1'b1; icache_miss_addr = 20'h00124; dcache_miss = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (icache_fetch || dcache_fetch) nfetch++;
      mem_valid = 1'b0;
      if (pend) begin mem_valid = 1'b1; mem_rdata = $urandom; pend = 1'b0; end
      if (mem_req) begin
        nreq++;
        if (nreq == 1) pend = 1'b1;
        else begin reached = 1'b1; break; end
      end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL rst_mid_second_req not seen"); end
    @(negedge clk);  // WAIT of second word
    checks++;
    if (busy !== 1'b1 || nfetch !== 1) begin
      failures++; $display("FAIL rst_mid_pre got busy=%b fetches=%0d exp busy=1 fetches=1", busy, nfetch);
    end
    rst = 1'b1; icache_miss = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, mem_req, icache_fetch, dcache_fetch} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_post got=%b exp=0000", {busy, mem_req, icache_fetch, dcache_fetch});
    end
    rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    nfetch = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (icache_fetch || dcache_fetch || mem_req || busy) nfetch++;
    end
    checks++;
    if (nfetch !== 0) begin failures++; $display("FAIL rst_mid_late_valid activity_cycles=%0d exp=0", nfetch); end
    // Last grant returns to I-side, so the first tie goes to D under either policy.
    tb_last = 1'b0;
    icache_miss = 1'b1; dcache_miss = 1'b1;
    icache_miss_addr = 20'h01000; dcache_miss_addr = 20'h02000;
    run_burst(1, 1'b0, 1'b0);
    icache_miss = 1'b0; dcache_miss = 1'b0;
    checks++;
    if (obs_fside.size() !== BW || obs_fside[0] !== 1'b1) begin
      failures++; $display("FAIL rst_tie_grant got fetches=%0d side=%b exp fetches=%0d side=1",
                           obs_fside.size(), (obs_fside.size() > 0) ? obs_fside[0] : 1'bx, BW);
    end
    repeat (2) @(negedge clk);
    $display("test_reset_mid_burst done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_spurious_valid();
    test_bursts();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
